// File: rtl/room_occupancy_counter_pkg.sv
// -----------------------------------------------------------------------------
// room_occupancy_counter_pkg
// Shared definitions for the room occupancy counter:
//   door_state_e  - per-door passage tracker states
//   *_P           - photocell pair codes, pair = {wej, wyj}, 1 = beam clear
// -----------------------------------------------------------------------------
package room_occupancy_counter_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      E1    = 3'd1,   // entry: outer beam broken
      E2    = 3'd2,   // entry: both beams broken
      E3    = 3'd3,   // entry: inner beam broken only
      X1    = 3'd4,   // exit: inner beam broken
      X2    = 3'd5,   // exit: both beams broken
      X3    = 3'd6,   // exit: outer beam broken only
      ABORT = 3'd7    // unexpected pattern; wait for both beams clear
   } door_state_e;

   localparam logic [1:0] IDLE_P  = 2'b11;  // both beams clear
   localparam logic [1:0] OUTER_P = 2'b01;  // outer beam broken only
   localparam logic [1:0] BOTH_P  = 2'b00;  // both beams broken
   localparam logic [1:0] INNER_P = 2'b10;  // inner beam broken only

endpackage : room_occupancy_counter_pkg

// File: rtl/room_occupancy_counter_door_fsm.sv
// -----------------------------------------------------------------------------
// door_fsm
// Tracks one doorway's photocell pair and flags a completed passage.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset
//   wej  in   outer photocell (1 = clear)
//   wyj  in   inner photocell (1 = clear)
//   inc  out  one-cycle Mealy pulse: entry completes this cycle
//   dec  out  one-cycle Mealy pulse: exit completes this cycle
// -----------------------------------------------------------------------------
module door_fsm
   import room_occupancy_counter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic wej,
   input  logic wyj,
   output logic inc,
   output logic dec
);

   door_state_e state_q, state_d;
   logic [1:0]  p;

   assign p = {wej, wyj};

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      inc     = 1'b0;
      dec     = 1'b0;
      unique case (state_q)
         IDLE: case (p)
            OUTER_P: state_d = E1;
            INNER_P: state_d = X1;
            BOTH_P:  state_d = ABORT;
            default: ;
         endcase
         E1: case (p)
            BOTH_P:  state_d = E2;
            IDLE_P:  state_d = IDLE;
            INNER_P: state_d = ABORT;
            default: ;
         endcase
         E2: case (p)
            INNER_P: state_d = E3;
            OUTER_P: state_d = E1;
            IDLE_P:  state_d = IDLE;
            default: ;
         endcase
         E3: case (p)
            IDLE_P: begin
               state_d = IDLE;
               // A passage cut short by reset must not be counted.
               inc     = ~rst;
            end
            BOTH_P:  state_d = E2;
            OUTER_P: state_d = ABORT;
            default: ;
         endcase
         X1: case (p)
            BOTH_P:  state_d = X2;
            IDLE_P:  state_d = IDLE;
            OUTER_P: state_d = ABORT;
            default: ;
         endcase
         X2: case (p)
            OUTER_P: state_d = X3;
            INNER_P: state_d = X1;
            IDLE_P:  state_d = IDLE;
            default: ;
         endcase
         X3: case (p)
            IDLE_P: begin
               state_d = IDLE;
               dec     = ~rst;
            end
            BOTH_P:  state_d = X2;
            INNER_P: state_d = ABORT;
            default: ;
         endcase
         ABORT: if (p == IDLE_P) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

endmodule : door_fsm

// File: rtl/room_occupancy_counter.sv
// -----------------------------------------------------------------------------
// room_occupancy_counter
// Counts people in a room from N_DOORS pairs of photocells.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   wej    in   [N_DOORS] outer photocells (1 = clear)
//   wyj    in   [N_DOORS] inner photocells (1 = clear)
//   clr    in   clears count and sticky flags (door trackers untouched)
//   cnt    out  [CNT_W] current occupancy, saturating
//   full   out  cnt >= CAPACITY
//   empty  out  cnt == 0
//   ovf    out  sticky: count clamped at its maximum
//   unf    out  sticky: count clamped at zero
// -----------------------------------------------------------------------------
module room_occupancy_counter
   import room_occupancy_counter_pkg::*;
#(
   parameter int N_DOORS  = 2,
   parameter int CNT_W    = 8,
   parameter int CAPACITY = 200
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_DOORS-1:0] wej,
   input  logic [N_DOORS-1:0] wyj,
   input  logic               clr,
   output logic [CNT_W-1:0]   cnt,
   output logic               full,
   output logic               empty,
   output logic               ovf,
   output logic               unf
);

   localparam int PC_W  = $clog2(N_DOORS + 1);
   localparam int DW    = PC_W + 1;
   // Sum is at least CNT_W+2 bits so neither direction can wrap.
   localparam int SUM_W = (CNT_W + 2 > DW + 1) ? CNT_W + 2 : DW + 1;
   localparam logic signed [SUM_W-1:0] MAX_S =
      {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   logic [N_DOORS-1:0]       inc, dec;
   logic [PC_W-1:0]          n_inc, n_dec;
   logic signed [DW-1:0]     delta;
   logic signed [SUM_W-1:0]  delta_ext, cnt_ext, sum;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     ovf_q, ovf_d, unf_q, unf_d;

   for (genvar i = 0; i < N_DOORS; i++) begin : g_door
      door_fsm u_door (
         .clk (clk),
         .rst (rst),
         .wej (wej[i]),
         .wyj (wyj[i]),
         .inc (inc[i]),
         .dec (dec[i])
      );
   end

   always_comb begin
      n_inc = '0;
      n_dec = '0;
      for (int i = 0; i < N_DOORS; i++) begin
         n_inc = n_inc + PC_W'(inc[i]);
         n_dec = n_dec + PC_W'(dec[i]);
      end
      // Entries and exits in the same cycle net out before clamping.
      delta     = $signed({1'b0, n_inc}) - $signed({1'b0, n_dec});
      delta_ext = {{(SUM_W-DW){delta[DW-1]}}, delta};
      cnt_ext   = {{(SUM_W-CNT_W){1'b0}}, cnt_q};
      sum       = cnt_ext + delta_ext;

      cnt_d = sum[CNT_W-1:0];
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (sum < 0) begin
         cnt_d = '0;
         unf_d = 1'b1;
      end else if (sum > MAX_S) begin
         cnt_d = '1;
         ovf_d = 1'b1;
      end

      if (clr) begin
         cnt_d = '0;
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
   end

   // NOTE: only the small count/flag registers are reset; reset is
   // synchronous, so it is simply the highest-priority branch.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign cnt   = cnt_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;
   assign full  = (cnt_q >= CNT_W'(CAPACITY));
   assign empty = (cnt_q == '0);

endmodule : room_occupancy_counter

// File: tb/tb_room_occupancy_counter.sv
// -----------------------------------------------------------------------------
// tb_room_occupancy_counter
// Directed bench for room_occupancy_counter with N_DOORS=2, CNT_W=4,
// CAPACITY=10. Inputs change on the falling edge; outputs are checked on
// the following falling edge, after the rising edge that sampled them.
// -----------------------------------------------------------------------------
module tb_room_occupancy_counter;

   localparam int N_DOORS  = 2;
   localparam int CNT_W    = 4;
   localparam int CAPACITY = 10;

   // Pass modes for a door over a four-cycle passage window.
   localparam int M_IDLE  = 0;
   localparam int M_ENTRY = 1;
   localparam int M_EXIT  = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic [N_DOORS-1:0] wej;
   logic [N_DOORS-1:0] wyj;
   logic               clr;
   logic [CNT_W-1:0]   cnt;
   logic               full, empty, ovf, unf;

   int n_assert = 0;
   int n_fail   = 0;

   room_occupancy_counter #(
      .N_DOORS  (N_DOORS),
      .CNT_W    (CNT_W),
      .CAPACITY (CAPACITY)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .wej   (wej),
      .wyj   (wyj),
      .clr   (clr),
      .cnt   (cnt),
      .full  (full),
      .empty (empty),
      .ovf   (ovf),
      .unf   (unf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply pairs {wej,wyj} for door0/door1 plus clr for one clock.
   task automatic tick(input logic [1:0] p0, input logic [1:0] p1,
                       input logic c);
      wej = {p1[1], p0[1]};
      wyj = {p1[0], p0[0]};
      clr = c;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [1:0] pat(input int mode, input int k);
      logic [1:0] ent [4];
      logic [1:0] ext [4];
      ent = '{2'b01, 2'b00, 2'b10, 2'b11};
      ext = '{2'b10, 2'b00, 2'b01, 2'b11};
      case (mode)
         M_ENTRY: return ent[k];
         M_EXIT:  return ext[k];
         default: return 2'b11;
      endcase
   endfunction

   // Full four-cycle passage; both doors complete on the same cycle.
   task automatic pass(input int m0, input int m1);
      for (int k = 0; k < 4; k++) tick(pat(m0, k), pat(m1, k), 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      wej = '1;
      wyj = '1;
      @(negedge clk);
      tick(2'b11, 2'b11, 1'b0);
      tick(2'b11, 2'b11, 1'b0);
      rst = 1'b0;

      // Reset state.
      check("rst_cnt",   cnt,   0);
      check("rst_full",  full,  0);
      check("rst_empty", empty, 1);
      check("rst_ovf",   ovf,   0);
      check("rst_unf",   unf,   0);

      // Single entry on door0: count appears the cycle after 11.
      tick(2'b11, 2'b11, 1'b0);
      tick(2'b01, 2'b11, 1'b0);
      tick(2'b00, 2'b11, 1'b0);
      tick(2'b10, 2'b11, 1'b0);
      check("entry_pre_cnt",   cnt,   0);
      check("entry_pre_empty", empty, 1);
      tick(2'b11, 2'b11, 1'b0);
      check("entry_cnt",   cnt,   1);
      check("entry_empty", empty, 0);

      // Build up to 5.
      for (int i = 0; i < 4; i++) pass(M_ENTRY, M_IDLE);
      check("build5_cnt", cnt, 5);

      // Simultaneous entry + exit nets to zero; double entry adds two.
      pass(M_ENTRY, M_EXIT);
      check("net_zero_cnt", cnt, 5);
      pass(M_ENTRY, M_ENTRY);
      check("double_entry_cnt", cnt, 7);

      // Backout on door0: no event, tracker returns to IDLE.
      tick(2'b11, 2'b11, 1'b0);
      tick(2'b01, 2'b11, 1'b0);
      tick(2'b00, 2'b11, 1'b0);
      tick(2'b01, 2'b11, 1'b0);
      tick(2'b11, 2'b11, 1'b0);
      check("backout_cnt", cnt, 7);
      pass(M_ENTRY, M_IDLE);
      check("after_backout_cnt", cnt, 8);

      // Fill to capacity.
      pass(M_ENTRY, M_IDLE);
      check("cnt9_full", full, 0);
      pass(M_ENTRY, M_IDLE);
      check("cnt10_cnt",  cnt,  10);
      check("cnt10_full", full, 1);

      // Up to the maximum: landing exactly on 15 is not an overflow.
      for (int i = 0; i < 5; i++) pass(M_ENTRY, M_IDLE);
      check("max_cnt", cnt, 15);
      check("max_ovf", ovf, 0);
      pass(M_ENTRY, M_IDLE);
      check("sat_cnt", cnt, 15);
      check("sat_ovf", ovf, 1);

      // Clear drops count and flags.
      tick(2'b11, 2'b11, 1'b1);
      check("clr_cnt",   cnt,   0);
      check("clr_ovf",   ovf,   0);
      check("clr_empty", empty, 1);

      // Exit at zero saturates and flags underflow.
      pass(M_IDLE, M_EXIT);
      check("unf_cnt", cnt, 0);
      check("unf_flag", unf, 1);
      tick(2'b11, 2'b11, 1'b1);
      check("unf_clr", unf, 0);

      // clr on the completing cycle drops the entry.
      tick(2'b01, 2'b11, 1'b0);
      tick(2'b00, 2'b11, 1'b0);
      tick(2'b10, 2'b11, 1'b0);
      tick(2'b11, 2'b11, 1'b1);
      check("clr_wins_cnt", cnt, 0);

      // clr mid-passage leaves the door tracker alone.
      tick(2'b01, 2'b11, 1'b0);
      tick(2'b00, 2'b11, 1'b1);
      tick(2'b10, 2'b11, 1'b0);
      tick(2'b11, 2'b11, 1'b0);
      check("clr_mid_cnt", cnt, 1);

      // Reset with door0 in E2 discards the passage; 10,11 then walks
      // X1 -> IDLE without any event.
      tick(2'b01, 2'b11, 1'b0);
      tick(2'b00, 2'b11, 1'b0);
      rst = 1'b1;
      tick(2'b00, 2'b11, 1'b1);
      rst = 1'b0;
      check("rst_mid_cnt", cnt, 0);
      tick(2'b10, 2'b11, 1'b0);
      tick(2'b11, 2'b11, 1'b0);
      check("rst_mid_after_cnt", cnt, 0);
      check("rst_mid_after_unf", unf, 0);
      pass(M_ENTRY, M_IDLE);
      check("rst_mid_recover_cnt", cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule : tb_room_occupancy_counter

// File: doc/room_occupancy_counter.md
ROOM_OCCUPANCY_COUNTER -- requirements
Module: room_occupancy_counter

Interface
REQ-001 Parameter N_DOORS, default 2: number of independent doorways, 1..8.
REQ-002 Parameter CNT_W, default 8: occupancy counter width; MAX_CNT = 2**CNT_W-1.
REQ-003 Parameter CAPACITY, default 200: occupancy at or above which full asserts; 1..MAX_CNT.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 wej  in  N_DOORS  outer photocell per door; 1 = beam clear, 0 = beam broken; synchronous to clk.
REQ-007 wyj  in  N_DOORS  inner photocell per door; same encoding.
REQ-008 clr  in  1  synchronous counter/flag clear.
REQ-009 cnt  out  CNT_W  current occupancy.
REQ-010 full  out  1  cnt >= CAPACITY.
REQ-011 empty  out  1  cnt == 0.
REQ-012 ovf  out  1  sticky, set on upper saturation.
REQ-013 unf  out  1  sticky, set on lower saturation.

Function
REQ-014 Each door shall have its own FSM on pair p = {wej[i],wyj[i]}; states IDLE, E1, E2, E3, X1, X2, X3, ABORT.
REQ-015 IDLE: p=01 -> E1; 10 -> X1; 00 -> ABORT; 11 -> stay.
REQ-016 E1: 00 -> E2; 11 -> IDLE, no event; 10 -> ABORT; 01 -> stay.
REQ-017 E2: 10 -> E3; 01 -> E1; 11 -> IDLE, no event; 00 -> stay.
REQ-018 E3: 11 -> IDLE with one-cycle inc[i]; 00 -> E2; 01 -> ABORT; 10 -> stay.
REQ-019 X1/X2/X3 shall mirror E1/E2/E3 with 01 and 10 swapped; X3 -> IDLE on 11 produces dec[i].
REQ-020 ABORT: 11 -> IDLE, no event; otherwise stay.
REQ-021 inc[i]/dec[i] shall be Mealy outputs of the current state and p; cnt reflects the event on the edge that samples 11, i.e. visible the cycle after 11 is presented (latency 1).
REQ-022 Per cycle, delta = popcount(inc) - popcount(dec), computed signed, wide enough for +/-N_DOORS.
REQ-023 cnt_next = cnt + delta clamped to [0, MAX_CNT]; computed in CNT_W+2 bits, no wrap-around.
REQ-024 Clamp at MAX_CNT shall set ovf; clamp at 0 with delta<0 shall set unf; simultaneous entries and exits net out before clamping.
REQ-025 clr shall set cnt=0, ovf=0 and unf=0; clr wins over all events in the same cycle (events dropped); door FSMs are unaffected.
REQ-026 full and empty shall be combinational decodes of registered cnt.

Reset
REQ-027 rst shall set all door FSMs to IDLE, cnt=0, ovf=0, unf=0; hence full=0 and empty=1.
REQ-028 rst mid-sequence shall discard the partial passage; no inc/dec is produced during or for it after reset.
REQ-029 rst shall take priority over clr and all sensor activity.

Structure
REQ-030 Shared package shall hold the door-state enum and the sensor-pair constants (IDLE_P=11, OUTER_P=01, BOTH_P=00, INNER_P=10).
REQ-031 The per-door FSM shall be sub-module door_fsm (clk, rst, wej, wyj -> inc, dec), instantiated N_DOORS times by generate.
REQ-032 The top level shall contain only the popcount/delta, saturating counter and flag logic.

Verification (N_DOORS=2, CNT_W=4, CAPACITY=10)
REQ-033 Door0 p = 11,01,00,10,11 from cnt=0 -> cnt=1 one cycle after 11; empty 1->0.
REQ-034 Door0 entry and door1 exit completing on the same cycle at cnt=5 -> cnt stays 5; two simultaneous entries at cnt=5 -> cnt=7.
REQ-035 Door0 backout 11,01,00,01,11 -> no event, cnt unchanged, FSM back in IDLE.
REQ-036 cnt=0, door1 exit -> cnt=0, unf=1; then clr -> unf=0; clr on the same cycle as an entry -> cnt=0.
REQ-037 Entries up to cnt=10 -> full=1 at 10; at cnt=15 one more entry -> cnt=15, ovf=1.
REQ-038 rst with door0 in E2, then p=10,11 -> no inc, cnt=0 (door passes X1 -> IDLE).
